// File: rtl/defuse_sweep_ctrl_pkg.sv
// Shared board definitions for the neighbour-defuse sweep sequencer:
// level encodings, board sizes, level-to-size mapping and FSM states.
package defuse_sweep_ctrl_pkg;

  localparam int unsigned LEVEL_W = 2;
  localparam int unsigned COORD_W = 5;
  localparam int unsigned PASS_W  = 6;

  localparam logic [LEVEL_W-1:0] LVL_EASY   = 2'd1;
  localparam logic [LEVEL_W-1:0] LVL_MEDIUM = 2'd2;
  localparam logic [LEVEL_W-1:0] LVL_HARD   = 2'd3;

  localparam logic [COORD_W-1:0] SIZE_EASY   = 5'd8;
  localparam logic [COORD_W-1:0] SIZE_MEDIUM = 5'd10;
  localparam logic [COORD_W-1:0] SIZE_HARD   = 5'd16;

  typedef enum logic [2:0] {
    IDLE,
    SWEEP,
    DRAIN,
    CHECK,
    DONE
  } sweep_state_e;

  // Level 0 never reaches this (start is rejected), so it falls back to 8.
  function automatic logic [COORD_W-1:0] level_to_size(input logic [LEVEL_W-1:0] level);
    case (level)
      LVL_MEDIUM: return SIZE_MEDIUM;
      LVL_HARD:   return SIZE_HARD;
      default:    return SIZE_EASY;
    endcase
  endfunction

endpackage

// File: rtl/defuse_sweep_ctrl_if.sv
// Handshake/bus bundle between click logic, the sweep sequencer and the
// defuse-propagation datapath.
interface defuse_sweep_ctrl_if;
  import defuse_sweep_ctrl_pkg::*;

  logic [LEVEL_W-1:0] level;
  logic               start;
  logic               cell_changed;
  logic [COORD_W-1:0] arr_x_refresh;
  logic [COORD_W-1:0] arr_y_refresh;
  logic               sweep_valid;
  logic               busy;
  logic               done;
  logic               timeout;
  logic [PASS_W-1:0]  pass_cnt;

  modport master (
    output level, start, cell_changed,
    input  arr_x_refresh, arr_y_refresh, sweep_valid, busy, done, timeout, pass_cnt
  );

  modport slave (
    input  level, start, cell_changed,
    output arr_x_refresh, arr_y_refresh, sweep_valid, busy, done, timeout, pass_cnt
  );

endinterface

// File: rtl/defuse_sweep_ctrl_sweep_coord_counter.sv
// Raster x/y counter over an N x N board: x runs fastest, both wrap to 0
// after (N-1, N-1). Clear has priority over enable.
module defuse_sweep_ctrl_sweep_coord_counter
  import defuse_sweep_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [COORD_W-1:0] size_i,
  input  logic               clr_i,
  input  logic               en_i,
  output logic [COORD_W-1:0] x_o,
  output logic [COORD_W-1:0] y_o,
  output logic               last_c_o
);

  logic [COORD_W-1:0] x_q, x_d;
  logic [COORD_W-1:0] y_q, y_d;
  logic               x_wrap_c;
  logic               y_wrap_c;

  always_comb begin
    x_wrap_c = (x_q == size_i - COORD_W'(1));
    y_wrap_c = (y_q == size_i - COORD_W'(1));
    x_d      = x_q;
    y_d      = y_q;
    if (clr_i) begin
      x_d = '0;
      y_d = '0;
    end else if (en_i) begin
      if (x_wrap_c) begin
        x_d = '0;
        y_d = y_wrap_c ? '0 : y_q + COORD_W'(1);
      end else begin
        x_d = x_q + COORD_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  assign x_o      = x_q;
  assign y_o      = y_q;
  assign last_c_o = x_wrap_c && y_wrap_c;

endmodule

// File: rtl/defuse_sweep_ctrl.sv
// Flood-reveal sequencer: repeats full-board coordinate sweeps until a pass
// produces no new defused cell (or the pass limit is hit), then pulses done.
module defuse_sweep_ctrl
  import defuse_sweep_ctrl_pkg::*;
#(
  parameter int unsigned DATAPATH_LAT = 1,
  parameter int unsigned MAX_PASSES   = 32
) (
  input  logic                clk,
  input  logic                rst,
  defuse_sweep_ctrl_if.slave  bus_if
);

  localparam int unsigned      DRAIN_W    = 3;
  localparam logic [DRAIN_W-1:0] LAST_DRAIN = DRAIN_W'(DATAPATH_LAT - 1);
  localparam logic [PASS_W-1:0]  LAST_PASS  = PASS_W'(MAX_PASSES - 1);

  sweep_state_e        state_q;
  logic [COORD_W-1:0]  size_q;
  logic [PASS_W-1:0]   pass_cnt_q;
  logic [DRAIN_W-1:0]  drain_cnt_q;
  logic                dirty_q;
  logic                timeout_q;
  logic                done_q;
  logic                busy_q;
  logic                sweep_valid_q;

  logic [COORD_W-1:0]  x_c;
  logic [COORD_W-1:0]  y_c;
  logic                last_cell_c;
  logic                cnt_en_c;

  // Coordinates advance only while sweeping and sit at (0,0) otherwise.
  assign cnt_en_c = (state_q == SWEEP);

  defuse_sweep_ctrl_sweep_coord_counter u_coord (
    .clk      (clk),
    .rst      (rst),
    .size_i   (size_q),
    .clr_i    (!cnt_en_c),
    .en_i     (cnt_en_c),
    .x_o      (x_c),
    .y_o      (y_c),
    .last_c_o (last_cell_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      size_q        <= SIZE_EASY;
      pass_cnt_q    <= '0;
      drain_cnt_q   <= '0;
      dirty_q       <= 1'b0;
      timeout_q     <= 1'b0;
      done_q        <= 1'b0;
      busy_q        <= 1'b0;
      sweep_valid_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus_if.start && (bus_if.level != '0)) begin
            state_q       <= SWEEP;
            size_q        <= level_to_size(bus_if.level);
            pass_cnt_q    <= '0;
            dirty_q       <= 1'b0;
            timeout_q     <= 1'b0;
            busy_q        <= 1'b1;
            sweep_valid_q <= 1'b1;
          end
        end
        SWEEP: begin
          dirty_q <= dirty_q | bus_if.cell_changed;
          if (last_cell_c) begin
            state_q       <= DRAIN;
            drain_cnt_q   <= '0;
            sweep_valid_q <= 1'b0;
          end
        end
        // Wait out the datapath pipeline so the last cells' results count.
        DRAIN: begin
          dirty_q <= dirty_q | bus_if.cell_changed;
          if (drain_cnt_q == LAST_DRAIN) begin
            state_q <= CHECK;
          end else begin
            drain_cnt_q <= drain_cnt_q + DRAIN_W'(1);
          end
        end
        CHECK: begin
          if (dirty_q && (pass_cnt_q < LAST_PASS)) begin
            state_q       <= SWEEP;
            dirty_q       <= 1'b0;
            pass_cnt_q    <= pass_cnt_q + PASS_W'(1);
            sweep_valid_q <= 1'b1;
          end else begin
            state_q   <= DONE;
            timeout_q <= dirty_q;
            done_q    <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus_if.arr_x_refresh = x_c;
  assign bus_if.arr_y_refresh = y_c;
  assign bus_if.sweep_valid   = sweep_valid_q;
  assign bus_if.busy          = busy_q;
  assign bus_if.done          = done_q;
  assign bus_if.timeout       = timeout_q;
  assign bus_if.pass_cnt      = pass_cnt_q;

endmodule

// File: tb/tb_defuse_sweep_ctrl.sv
// Scoreboard bench for defuse_sweep_ctrl: expected coordinates and run
// results are queued at stimulus time and popped as the DUT emits them.
module tb_defuse_sweep_ctrl;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  defuse_sweep_ctrl_if bus_if ();

  defuse_sweep_ctrl #(
    .DATAPATH_LAT (1),
    .MAX_PASSES   (3)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_if (bus_if)
  );

  typedef struct packed {
    logic [5:0] pass_cnt;
    logic       timeout;
  } res_t;

  logic [9:0] exp_xy_q[$];
  res_t       exp_res_q[$];

  int errors = 0;
  int checks = 0;
  int rel;
  int done_rel;
  int done_cnt;
  int valid_cnt;
  int max_coord;
  bit done_seen;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", tag, act, exp);
    end
  endtask

  task automatic monitor();
    logic [9:0] exp_xy;
    res_t       r;
    if (bus_if.sweep_valid) begin
      valid_cnt++;
      if (int'(bus_if.arr_x_refresh) > max_coord) max_coord = int'(bus_if.arr_x_refresh);
      if (int'(bus_if.arr_y_refresh) > max_coord) max_coord = int'(bus_if.arr_y_refresh);
      if (exp_xy_q.size() == 0) begin
        chk("xy_extra", 32'(exp_xy_q.size()), 32'd1);
      end else begin
        exp_xy = exp_xy_q.pop_front();
        chk("xy", 32'({bus_if.arr_x_refresh, bus_if.arr_y_refresh}), 32'(exp_xy));
      end
    end else begin
      chk("xy_idle", 32'({bus_if.arr_x_refresh, bus_if.arr_y_refresh}), 32'd0);
    end
    if (bus_if.done) begin
      done_seen = 1'b1;
      done_rel  = rel;
      done_cnt++;
      if (exp_res_q.size() == 0) begin
        chk("done_extra", 32'(exp_res_q.size()), 32'd1);
      end else begin
        r = exp_res_q.pop_front();
        chk("done_pass_cnt", 32'(bus_if.pass_cnt), 32'(r.pass_cnt));
        chk("done_timeout", 32'(bus_if.timeout), 32'(r.timeout));
        chk("done_busy", 32'(bus_if.busy), 32'd1);
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    rel++;
    monitor();
  endtask

  task automatic push_cells(input int n, input int count);
    int k;
    k = 0;
    for (int y = 0; y < n; y++) begin
      for (int x = 0; x < n; x++) begin
        if (k < count) exp_xy_q.push_back({5'(x), 5'(y)});
        k++;
      end
    end
  endtask

  task automatic expect_run(input int n, input int passes, input logic [5:0] pc, input logic to);
    res_t r;
    for (int p = 0; p < passes; p++) push_cells(n, n * n);
    r.pass_cnt = pc;
    r.timeout  = to;
    exp_res_q.push_back(r);
  endtask

  task automatic start_run(input logic [1:0] lvl);
    bus_if.level = lvl;
    bus_if.start = 1'b1;
    rel       = 0;
    done_seen = 1'b0;
    done_cnt  = 0;
    valid_cnt = 0;
    max_coord = 0;
    tick();
    bus_if.start = 1'b0;
  endtask

  // Drives cell_changed over a relative-cycle window, optionally pulses a
  // spurious start with a new level, and stops at done or the cycle budget.
  task automatic run_until_done(input string tag, input int cc_from, input int cc_to,
                                input int restart_rel, input int budget);
    while (!done_seen && rel < budget) begin
      bus_if.cell_changed = (rel >= cc_from) && (rel <= cc_to);
      bus_if.start        = (rel == restart_rel);
      if (rel == restart_rel) bus_if.level = 2'd3;
      tick();
    end
    bus_if.cell_changed = 1'b0;
    bus_if.start        = 1'b0;
    if (!done_seen) chk({tag, "_no_done"}, 32'(done_seen), 32'd1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, want finish before time limit");
    $fatal(1);
  end

  initial begin
    rst                 = 1'b1;
    bus_if.level        = 2'd0;
    bus_if.start        = 1'b0;
    bus_if.cell_changed = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    chk("rst_valid", 32'(bus_if.sweep_valid), 32'd0);
    chk("rst_busy", 32'(bus_if.busy), 32'd0);
    chk("rst_done", 32'(bus_if.done), 32'd0);
    chk("rst_timeout", 32'(bus_if.timeout), 32'd0);
    chk("rst_pass_cnt", 32'(bus_if.pass_cnt), 32'd0);
    chk("rst_xy", 32'({bus_if.arr_x_refresh, bus_if.arr_y_refresh}), 32'd0);

    // 1: clean single pass on 8x8
    expect_run(8, 1, 6'd0, 1'b0);
    start_run(2'd1);
    run_until_done("t1", 1, 0, 0, 300);
    chk("t1_done_cyc", 32'(done_rel), 32'd67);
    chk("t1_valid_cnt", 32'(valid_cnt), 32'd64);
    tick();
    chk("t1_busy_after", 32'(bus_if.busy), 32'd0);
    chk("t1_xy_left", 32'(exp_xy_q.size()), 32'd0);

    // 2: 16x16, one change in pass 0
    expect_run(16, 2, 6'd1, 1'b0);
    start_run(2'd3);
    run_until_done("t2", 10, 10, 0, 1000);
    chk("t2_done_cyc", 32'(done_rel), 32'd517);
    chk("t2_valid_cnt", 32'(valid_cnt), 32'd512);
    repeat (2) tick();

    // 3: 10x10, change reported only in the drain cycle
    expect_run(10, 2, 6'd1, 1'b0);
    start_run(2'd2);
    run_until_done("t3", 101, 101, 0, 500);
    chk("t3_done_cyc", 32'(done_rel), 32'd205);
    chk("t3_max_coord", 32'(max_coord), 32'd9);
    chk("t3_valid_cnt", 32'(valid_cnt), 32'd200);
    repeat (2) tick();

    // 4: always dirty, stops at the pass limit
    expect_run(8, 3, 6'd2, 1'b1);
    start_run(2'd1);
    run_until_done("t4", 1, 100000, 0, 500);
    chk("t4_done_cyc", 32'(done_rel), 32'd199);
    chk("t4_valid_cnt", 32'(valid_cnt), 32'd192);
    repeat (3) tick();
    chk("t4_hold_timeout", 32'(bus_if.timeout), 32'd1);
    chk("t4_hold_pass_cnt", 32'(bus_if.pass_cnt), 32'd2);
    chk("t4_idle_busy", 32'(bus_if.busy), 32'd0);

    // 5: start and level change mid-run are ignored
    expect_run(8, 1, 6'd0, 1'b0);
    start_run(2'd1);
    chk("t5_timeout_clr", 32'(bus_if.timeout), 32'd0);
    chk("t5_pass_clr", 32'(bus_if.pass_cnt), 32'd0);
    run_until_done("t5", 1, 0, 20, 300);
    chk("t5_done_cyc", 32'(done_rel), 32'd67);
    chk("t5_max_coord", 32'(max_coord), 32'd7);
    repeat (5) tick();
    chk("t5_done_cnt", 32'(done_cnt), 32'd1);
    bus_if.level = 2'd0;
    bus_if.start = 1'b1;
    tick();
    bus_if.start = 1'b0;
    tick();
    chk("t5_lvl0_busy", 32'(bus_if.busy), 32'd0);
    chk("t5_lvl0_valid", 32'(bus_if.sweep_valid), 32'd0);

    // 6: reset in pass 1 at cell (3,5), then a fresh run
    push_cells(8, 64);
    push_cells(8, 44);
    start_run(2'd1);
    while (rel < 110) begin
      bus_if.cell_changed = (rel == 5);
      tick();
    end
    bus_if.cell_changed = 1'b0;
    chk("t6_at_cell", 32'({bus_if.arr_x_refresh, bus_if.arr_y_refresh}), 32'({5'd3, 5'd5}));
    chk("t6_at_pass", 32'(bus_if.pass_cnt), 32'd1);
    rst = 1'b1;
    tick();
    chk("t6_rst_valid", 32'(bus_if.sweep_valid), 32'd0);
    chk("t6_rst_busy", 32'(bus_if.busy), 32'd0);
    chk("t6_rst_done", 32'(bus_if.done), 32'd0);
    chk("t6_rst_pass", 32'(bus_if.pass_cnt), 32'd0);
    chk("t6_rst_timeout", 32'(bus_if.timeout), 32'd0);
    chk("t6_xy_left", 32'(exp_xy_q.size()), 32'd0);
    rst = 1'b0;
    repeat (4) tick();
    chk("t6_no_done", 32'(done_cnt), 32'd0);
    expect_run(8, 1, 6'd0, 1'b0);
    start_run(2'd1);
    chk("t6_fresh_pass", 32'(bus_if.pass_cnt), 32'd0);
    run_until_done("t6", 1, 0, 0, 300);
    chk("t6_done_cyc", 32'(done_rel), 32'd67);
    repeat (2) tick();
    chk("end_xy_left", 32'(exp_xy_q.size()), 32'd0);
    chk("end_res_left", 32'(exp_res_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
